// File: rtl/rf_alu_pipe.sv
// Issue/execute/writeback ALU pipeline for a 2R1W register file.
// Operands are forwarded from EX (live ALU output) and WB, so it never stalls.
module rf_alu_pipe #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5,
    parameter int BW_CNT  = 32
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [3:0]         i_op,
    input  logic [BW_ADDR-1:0] i_rd,
    input  logic [BW_ADDR-1:0] i_rs1,
    input  logic [BW_ADDR-1:0] i_rs2,
    input  logic [BW_DATA-1:0] i_imm,
    input  logic               i_use_imm,
    output logic [BW_ADDR-1:0] o_rf_rd_addr0,
    output logic [BW_ADDR-1:0] o_rf_rd_addr1,
    input  logic [BW_DATA-1:0] i_rf_rd_data0,
    input  logic [BW_DATA-1:0] i_rf_rd_data1,
    output logic               o_rf_wr_en,
    output logic [BW_ADDR-1:0] o_rf_wr_addr,
    output logic [BW_DATA-1:0] o_rf_wr_data,
    output logic [BW_CNT-1:0]  o_retire_cnt
);
    localparam int BW_SH = $clog2(BW_DATA);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    logic               r_ready;
    logic               r_ex_vld;
    logic [3:0]         r_ex_op;
    logic [BW_ADDR-1:0] r_ex_rd;
    logic [BW_DATA-1:0] r_ex_a;
    logic [BW_DATA-1:0] r_ex_b;
    logic               r_wb_vld;
    logic [BW_ADDR-1:0] r_wb_rd;
    logic [BW_DATA-1:0] r_wb_data;
    logic [BW_CNT-1:0]  r_cnt;

    logic               w_accept;
    logic [BW_DATA-1:0] w_alu;
    logic [BW_DATA-1:0] w_rs1_val;
    logic [BW_DATA-1:0] w_rs2_val;
    logic [BW_DATA-1:0] w_b_sel;
    logic [BW_SH-1:0]   w_sh;

    // Youngest producer wins: EX holds a newer value than WB, which is newer than the file.
    function automatic logic [BW_DATA-1:0] resolve(
        input logic [BW_ADDR-1:0] rs,
        input logic [BW_DATA-1:0] rf_val,
        input logic               ex_vld,
        input logic [BW_ADDR-1:0] ex_rd,
        input logic [BW_DATA-1:0] ex_val,
        input logic               wb_vld,
        input logic [BW_ADDR-1:0] wb_rd,
        input logic [BW_DATA-1:0] wb_val
    );
        if (rs == '0)
            return '0;
        else if (ex_vld && ex_rd == rs)
            return ex_val;
        else if (wb_vld && wb_rd == rs)
            return wb_val;
        else
            return rf_val;
    endfunction

    assign o_ready       = r_ready;
    assign w_accept      = i_valid & r_ready;
    assign o_rf_rd_addr0 = i_rs1;
    assign o_rf_rd_addr1 = i_rs2;

    assign w_rs1_val = resolve(i_rs1, i_rf_rd_data0, r_ex_vld, r_ex_rd, w_alu,
                               r_wb_vld, r_wb_rd, r_wb_data);
    assign w_rs2_val = resolve(i_rs2, i_rf_rd_data1, r_ex_vld, r_ex_rd, w_alu,
                               r_wb_vld, r_wb_rd, r_wb_data);
    assign w_b_sel   = i_use_imm ? i_imm : w_rs2_val;
    assign w_sh      = r_ex_b[BW_SH-1:0];

    always_comb begin
        w_alu = '0;
        case (r_ex_op)
            OP_ADD:   w_alu = r_ex_a + r_ex_b;
            OP_SUB:   w_alu = r_ex_a - r_ex_b;
            OP_AND:   w_alu = r_ex_a & r_ex_b;
            OP_OR:    w_alu = r_ex_a | r_ex_b;
            OP_XOR:   w_alu = r_ex_a ^ r_ex_b;
            OP_SLL:   w_alu = r_ex_a << w_sh;
            OP_SRL:   w_alu = r_ex_a >> w_sh;
            OP_SRA:   w_alu = $unsigned($signed(r_ex_a) >>> w_sh);
            OP_SLT:   w_alu = {{(BW_DATA-1){1'b0}}, $signed(r_ex_a) < $signed(r_ex_b)};
            OP_SLTU:  w_alu = {{(BW_DATA-1){1'b0}}, r_ex_a < r_ex_b};
            OP_PASSB: w_alu = r_ex_b;
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ready   <= 1'b0;
            r_ex_vld  <= 1'b0;
            r_ex_op   <= '0;
            r_ex_rd   <= '0;
            r_ex_a    <= '0;
            r_ex_b    <= '0;
            r_wb_vld  <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_cnt     <= '0;
        end else begin
            r_ready  <= 1'b1;
            r_ex_vld <= w_accept;
            if (w_accept) begin
                r_ex_op <= i_op;
                r_ex_rd <= i_rd;
                r_ex_a  <= w_rs1_val;
                r_ex_b  <= w_b_sel;
            end
            r_wb_vld  <= r_ex_vld;
            r_wb_rd   <= r_ex_rd;
            r_wb_data <= w_alu;
            if (r_wb_vld)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Writes to r0 retire (counted) but never reach the file.
    assign o_rf_wr_en   = r_wb_vld && (r_wb_rd != '0);
    assign o_rf_wr_addr = r_wb_rd;
    assign o_rf_wr_data = r_wb_data;
    assign o_retire_cnt = r_cnt;

endmodule

// File: tb/tb_rf_alu_pipe.sv
// Directed bench for rf_alu_pipe with a behavioural 2R1W register file (BW_CNT=4 build).
module tb_rf_alu_pipe;
    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 5;
    localparam int BW_CNT  = 4;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
    localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;
    localparam logic [3:0] PASSB = 4'd10, RSV = 4'd13;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               valid = 1'b0;
    logic               ready;
    logic [3:0]         op = '0;
    logic [BW_ADDR-1:0] rd = '0, rs1 = '0, rs2 = '0;
    logic [BW_DATA-1:0] imm = '0;
    logic               use_imm = 1'b0;
    logic [BW_ADDR-1:0] ra0, ra1;
    logic [BW_DATA-1:0] rdat0, rdat1;
    logic               wr_en;
    logic [BW_ADDR-1:0] wr_addr;
    logic [BW_DATA-1:0] wr_data;
    logic [BW_CNT-1:0]  cnt;

    logic [BW_DATA-1:0] rf [32];
    logic [BW_ADDR-1:0] log_a [$];
    logic [BW_DATA-1:0] log_d [$];
    logic [BW_CNT-1:0]  exp_cnt;
    int                 n_pass = 0;
    int                 n_total = 0;

    always #5 clk = ~clk;

    rf_alu_pipe #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .BW_CNT(BW_CNT)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(ready),
        .i_op(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_use_imm(use_imm),
        .o_rf_rd_addr0(ra0), .o_rf_rd_addr1(ra1),
        .i_rf_rd_data0(rdat0), .i_rf_rd_data1(rdat1),
        .o_rf_wr_en(wr_en), .o_rf_wr_addr(wr_addr), .o_rf_wr_data(wr_data),
        .o_retire_cnt(cnt)
    );

    assign rdat0 = rf[ra0];
    assign rdat1 = rf[ra1];

    always @(posedge clk)
        if (wr_en) rf[wr_addr] <= wr_data;

    always @(negedge clk)
        if (wr_en) begin
            log_a.push_back(wr_addr);
            log_d.push_back(wr_data);
        end

    task automatic issue(input logic [3:0] o, input logic [4:0] d, input logic [4:0] a,
                         input logic [4:0] b, input logic [31:0] im, input logic ui);
        valid = 1'b1; op = o; rd = d; rs1 = a; rs2 = b; imm = im; use_imm = ui;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    // Compares the logged writes against an expected list (addresses and data).
    task automatic test_writes(input string name, input int n,
                               input logic [4:0] ea [16], input logic [31:0] ed [16]);
        n_total++;
        if (log_a.size() != n) begin
            $display("FAIL %s: write count got %0d want %0d", name, log_a.size(), n);
        end else begin
            n_pass++;
            for (int i = 0; i < n; i++) begin
                n_total++;
                if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
                    $display("FAIL %s[%0d]: got r%0d=%h want r%0d=%h",
                             name, i, log_a[i], log_d[i], ea[i], ed[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic check_cnt(input string name);
        n_total++;
        if (cnt !== exp_cnt) $display("FAIL %s: retire_cnt got %0d want %0d", name, cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if (ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || cnt !== '0)
            $display("FAIL reset_state: rdy=%b en=%b addr=%0d data=%h cnt=%0d want all 0",
                     ready, wr_en, wr_addr, wr_data, cnt);
        else n_pass++;
        rstn = 1'b1;
        n_total++;
        if (ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", ready);
        else n_pass++;
        clear_log();
        idle(4);
        n_total++;
        if (log_a.size() != 0) $display("FAIL idle_writes: got %0d want 0", log_a.size());
        else n_pass++;
        exp_cnt = '0;
        check_cnt("idle_cnt");
    endtask

    task automatic test_add();
        clear_log();
        issue(ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
        n_total++;
        if (wr_en !== 1'b0) $display("FAIL add_early: wr_en got %b want 0", wr_en);
        else n_pass++;
        idle(1);
        n_total++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'd12)
            $display("FAIL add_wb: got en=%b r%0d=%h want en=1 r3=0000000c", wr_en, wr_addr, wr_data);
        else n_pass++;
        idle(1);
        exp_cnt += 4'd1;
        check_cnt("add_cnt");
        n_total++;
        if (rf[3] !== 32'd12) $display("FAIL add_rf: got %h want 0000000c", rf[3]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ea [16];
        logic [31:0] ed [16];
        clear_log();
        rf[3] = 32'hDEAD_BEEF;
        issue(ADD,  5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
        issue(SUB,  5'd4, 5'd3, 5'd1, 32'h0, 1'b0);
        issue(XOR_, 5'd5, 5'd4, 5'd3, 32'h0, 1'b0);
        idle(3);
        ea[0] = 5'd3; ed[0] = 32'd12;
        ea[1] = 5'd4; ed[1] = 32'd7;
        ea[2] = 5'd5; ed[2] = 32'h0000_000B;
        test_writes("chain", 3, ea, ed);
        exp_cnt += 4'd3;
        check_cnt("chain_cnt");
    endtask

    task automatic test_imm_shift();
        logic [4:0]  ea [16];
        logic [31:0] ed [16];
        clear_log();
        issue(PASSB, 5'd6,  5'd0, 5'd0, 32'h8000_0000, 1'b1);
        issue(SRA,   5'd7,  5'd6, 5'd0, 32'd4, 1'b1);
        issue(SRL,   5'd11, 5'd6, 5'd0, 32'd4, 1'b1);
        issue(SLT,   5'd8,  5'd6, 5'd1, 32'h0, 1'b0);
        issue(SLTU,  5'd12, 5'd6, 5'd1, 32'h0, 1'b0);
        issue(OR_,   5'd13, 5'd1, 5'd2, 32'h0, 1'b0);
        issue(AND_,  5'd14, 5'd1, 5'd2, 32'h0, 1'b0);
        issue(RSV,   5'd15, 5'd1, 5'd2, 32'h0, 1'b0);
        issue(SLL,   5'd16, 5'd1, 5'd0, 32'h23, 1'b1);
        idle(3);
        ea[0] = 5'd6;  ed[0] = 32'h8000_0000;
        ea[1] = 5'd7;  ed[1] = 32'hF800_0000;
        ea[2] = 5'd11; ed[2] = 32'h0800_0000;
        ea[3] = 5'd8;  ed[3] = 32'd1;
        ea[4] = 5'd12; ed[4] = 32'd0;
        ea[5] = 5'd13; ed[5] = 32'd7;
        ea[6] = 5'd14; ed[6] = 32'd5;
        ea[7] = 5'd15; ed[7] = 32'd0;
        ea[8] = 5'd16; ed[8] = 32'd40;
        test_writes("imm", 9, ea, ed);
        exp_cnt += 4'd9;
        check_cnt("imm_cnt");
    endtask

    task automatic test_reg0();
        logic [4:0]  ea [16];
        logic [31:0] ed [16];
        clear_log();
        issue(ADD, 5'd0, 5'd1, 5'd2, 32'h0, 1'b0);
        issue(ADD, 5'd9, 5'd0, 5'd1, 32'h0, 1'b0);
        idle(3);
        ea[0] = 5'd9; ed[0] = 32'd5;
        test_writes("reg0", 1, ea, ed);
        exp_cnt += 4'd2;
        check_cnt("reg0_cnt");
    endtask

    task automatic test_bubbles();
        logic [4:0]  ea [16];
        logic [31:0] ed [16];
        clear_log();
        for (int i = 0; i < 5; i++) begin
            issue(ADD, 5'(20 + i), 5'd1, 5'd0, 32'(i), 1'b1);
            idle(1);
            ea[i] = 5'(20 + i); ed[i] = 32'(5 + i);
        end
        idle(3);
        test_writes("bubble", 5, ea, ed);
        exp_cnt += 4'd5;
        check_cnt("bubble_cnt");
    endtask

    task automatic test_mid_reset();
        clear_log();
        rf[30] = 32'h0;
        issue(ADD, 5'd30, 5'd1, 5'd2, 32'h0, 1'b0);
        valid = 1'b1; op = ADD; rd = 5'd30; rs1 = 5'd1; rs2 = 5'd2; use_imm = 1'b0;
        rstn = 1'b0;
        #1;
        n_total++;
        if (ready !== 1'b0) $display("FAIL midreset_ready: got %b want 0", ready);
        else n_pass++;
        valid = 1'b0;
        idle(3);
        rstn = 1'b1;
        idle(3);
        n_total++;
        if (log_a.size() != 0 || rf[30] !== 32'h0)
            $display("FAIL midreset_drop: writes got %0d r30=%h want 0 writes r30=0",
                     log_a.size(), rf[30]);
        else n_pass++;
        exp_cnt = '0;
        check_cnt("midreset_cnt");
        n_total++;
        if (ready !== 1'b1) $display("FAIL midreset_ready_back: got %b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 15; i++) issue(ADD, 5'd17, 5'd1, 5'd2, 32'h0, 1'b0);
        idle(3);
        exp_cnt = 4'd15;
        check_cnt("wrap_max");
        issue(ADD, 5'd17, 5'd1, 5'd2, 32'h0, 1'b0);
        idle(3);
        exp_cnt = 4'd0;
        check_cnt("wrap_zero");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        exp_cnt = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_imm_shift();
        test_reg0();
        test_bubbles();
        test_mid_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rf_alu_pipe.md
Name: rf_alu_pipe

Overview:
- Three-stage issue/execute/writeback pipeline that drives both read ports and the write port of the team's 2R1W register file (BW_DATA x 2**BW_ADDR).
- Accepts one register-register or register-immediate ALU instruction per cycle over a valid/ready handshake.
- Reads operands combinationally from the register file, with full forwarding from the EX and WB stages.
- Writes results back two cycles after acceptance.

Parameters:
- BW_DATA, 32, datapath and register width (equal to register file BW_DATA)
- BW_ADDR, 5, register index width (equal to register file BW_ADDR)
- BW_CNT, 32, width of retired-instruction counter

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rstn  input  1  asynchronous active-low reset
- i_valid  input  1  instruction valid
- o_ready  output  1  block can accept instruction
- i_op  input  4  ALU opcode
- i_rd  input  BW_ADDR  destination register
- i_rs1  input  BW_ADDR  source register A
- i_rs2  input  BW_ADDR  source register B
- i_imm  input  BW_DATA  immediate
- i_use_imm  input  1  1: operand B = i_imm, else rs2 value
- o_rf_rd_addr0  output  BW_ADDR  to register file read port 0 (= i_rs1, combinational)
- o_rf_rd_addr1  output  BW_ADDR  to register file read port 1 (= i_rs2, combinational)
- i_rf_rd_data0  input  BW_DATA  from register file read port 0
- i_rf_rd_data1  input  BW_DATA  from register file read port 1
- o_rf_wr_en  output  1  register file write enable
- o_rf_wr_addr  output  BW_ADDR  register file write address
- o_rf_wr_data  output  BW_DATA  register file write data
- o_retire_cnt  output  BW_CNT  count of instructions written back

Behaviour:
- Reset (async, i_rstn=0): stage valids=0, o_ready=0, o_rf_wr_en=0, o_rf_wr_addr=0, o_rf_wr_data=0, o_retire_cnt=0.
- Mid-operation reset: in-flight instructions are dropped with no write. o_ready returns high on the first rising edge after i_rstn deasserts.
- o_ready is registered and is 1 whenever the block is out of reset. There are no stalls, because full forwarding removes all hazards.
- Accept when i_valid & o_ready at a rising edge (edge ending cycle N).
- Cycle N: operand values are resolved and latched into the EX register together with op, rd and the valid bit.
- Cycle N+1: the ALU computes combinationally. Result, rd and valid are latched into the WB register.
- Cycle N+2: o_rf_wr_en=1, o_rf_wr_addr=rd, o_rf_wr_data=result. The register file commits at the end of N+2.
- Operand resolution, per source, in priority order:
  - (1) index 0 -> 0;
  - (2) EX valid & EX rd==rs & EX rd!=0 -> live ALU output;
  - (3) WB valid & WB rd==rs & WB rd!=0 -> WB data;
  - (4) i_rf_rd_dataX.
- Register 0 reads as 0. A writeback with rd==0 keeps o_rf_wr_en=0 but still increments o_retire_cnt.
- Opcodes (A=rs1 value, B=rs2 value or imm):
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL A<<B[log2(BW_DATA)-1:0]
  - 6 SRL logical
  - 7 SRA arithmetic
  - 8 SLT signed (1/0)
  - 9 SLTU unsigned
  - 10 PASSB (B)
  - 11-15 reserved, result 0, still written back.
- Arithmetic is modulo 2**BW_DATA. Overflow is ignored and no flags are produced.
- o_retire_cnt increments by 1 on each cycle the WB stage is valid and wraps from all-ones to 0.
- Simultaneous accept and writeback are allowed every cycle, giving a sustained throughput of 1 instruction/cycle.
- When i_valid=0, the cycle inserts a bubble: the stage valid is 0 and no write occurs two cycles later.

Test Plan:
- Reset, then hold i_valid=0 -> o_rf_wr_en stays 0, o_retire_cnt=0, o_ready=1 from first edge after release; assert reset mid-stream -> no write issued for dropped instructions.
- Register file preloaded r1=5, r2=7; issue ADD r3,r1,r2 at cycle 0 -> cycle 2 o_rf_wr_en=1, addr=3, data=12; o_retire_cnt=1 after.
- Back-to-back chain:
  - Sequence: ADD r3,r1,r2 then SUB r4,r3,r1 then XOR r5,r4,r3 on consecutive cycles.
  - Forwarding covered: EX forward for the SUB, WB and EX forward for the XOR.
  - Required writes: r3=12, r4=7, r5=0x0000000B.
- Immediates/shifts: PASSB r6 imm=0x80000000; then SRA r7,r6 imm=4 -> 0xF8000000; SRL -> 0x08000000; SLT r8,r6,r1 -> 1; SLTU -> 0.
- Register 0: ADD r0,r1,r2 -> no write, retire_cnt still increments; subsequent ADD r9,r0,r1 -> r9=5 (not 12).
- Bubbles and wrap: alternate i_valid 1/0 for 10 cycles -> exactly 5 writes. Force o_retire_cnt near max (BW_CNT=4 build) -> 15 wraps to 0.
